// File: rtl/pll_lock_reset_seq_pkg.sv
// Shared definitions for the PLL lock / reset sequencer.
// Holds the FSM state encoding (fixed, visible on state_o for debug),
// the default timing parameters and a helper that sizes the shared
// cycle counter.
package pll_lock_reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    FAULT     = 2'd3
  } state_t;

  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_HOLD_CYCLES   = 16;

  // Width of a counter that must reach max(a,b)-1; at least one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_reset_seq_sync_ff.sv
// sync_ff: STAGES-deep single-bit synchroniser for an asynchronous flag.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, clears every stage to 0
//   d    - asynchronous input flag
//   q    - synchronised flag (last stage); a new d value sampled at
//          edge 0 appears on q after edge STAGES-1
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: sequences reset for the PLL-clocked datapath.
// Synchronises the PLL locked flag, keeps sys_rst asserted until lock has
// been stable for STABLE_CYCLES cycles, and on a lock loss in operation
// re-asserts sys_rst for at least HOLD_CYCLES cycles and counts the event.
// Ports:
//   clk             - PLL output clock, the only clock
//   rst             - synchronous active-high reset
//   locked          - PLL lock flag, asynchronous to clk
//   clear_count     - single-cycle pulse, clears lock_lost_count
//   sys_rst         - registered active-high reset for downstream logic
//   ready           - registered, high only in RUN
//   lock_lost_count - saturating count of RUN->FAULT transitions
//   state_o         - current FSM state (debug)
module pll_lock_reset_seq
  import pll_lock_reset_seq_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             clear_count,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] lock_lost_count,
  output logic [1:0]       state_o
);

  localparam int CW = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]    HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] COUNT_SAT   = '1;

  logic locked_s;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             sys_rst_reg, sys_rst_next;
  logic             ready_reg, ready_next;
  logic             lost_inc;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (locked),
    .q  (locked_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= WAIT_LOCK;
      cnt_reg     <= '0;
      count_reg   <= '0;
      sys_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      count_reg   <= count_next;
      sys_rst_reg <= sys_rst_next;
      ready_reg   <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lost_inc   = 1'b0;
    case (state_reg)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_next = STABILIZE;
          cnt_next   = '0;
        end
      end
      STABILIZE: begin
        // A dropout while stabilising is a glitch: restart, do not count.
        if (!locked_s) begin
          state_next = WAIT_LOCK;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_next = FAULT;
          cnt_next   = '0;
          lost_inc   = 1'b1;
        end
      end
      FAULT: begin
        // locked_s is deliberately ignored: the hold is always served in full.
        if (cnt_reg == HOLD_LAST) begin
          state_next = WAIT_LOCK;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register; being single flops they cannot glitch
    // and are mutually exclusive by construction.
    sys_rst_next = (state_next != RUN);
    ready_next   = (state_next == RUN);

    // A clear coinciding with an event leaves exactly that event counted.
    count_next = count_reg;
    if (clear_count) begin
      count_next = lost_inc ? CNT_W'(1) : '0;
    end else if (lost_inc && (count_reg != COUNT_SAT)) begin
      count_next = count_reg + 1'b1;
    end
  end

  assign sys_rst         = sys_rst_reg;
  assign ready           = ready_reg;
  assign lock_lost_count = count_reg;
  assign state_o         = state_reg;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
module tb_pll_lock_reset_seq;

  logic       clk;
  logic       rst;
  logic       locked;
  logic       clear_count;
  logic       sys_rst;
  logic       ready;
  logic [1:0] lock_lost_count;
  logic [1:0] state_o;

  int n_total = 0;
  int n_bad   = 0;

  pll_lock_reset_seq #(
    .STABLE_CYCLES(8),
    .HOLD_CYCLES  (4),
    .SYNC_STAGES  (2),
    .CNT_W        (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .locked         (locked),
    .clear_count    (clear_count),
    .sys_rst        (sys_rst),
    .ready          (ready),
    .lock_lost_count(lock_lost_count),
    .state_o        (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; outputs sampled and inputs driven 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int st, input int cnt);
    check({tag, ".state"}, state_o, st);
    check({tag, ".sys_rst"}, sys_rst, (st == 2) ? 0 : 1);
    check({tag, ".ready"}, ready, (st == 2) ? 1 : 0);
    check({tag, ".count"}, lock_lost_count, cnt);
  endtask

  // Clean lock from WAIT_LOCK with cleared synchroniser: locked=1 is first
  // sampled at edge 0, STABILIZE after edge 2, RUN after edge 10.
  task automatic clean_lock(input string tag, input int cnt);
    int st;
    locked = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      tick();
      st = (i < 2) ? 0 : (i < 10) ? 1 : 2;
      check_outs($sformatf("%s.e%0d", tag, i), st, cnt);
    end
    $display("lock %s: state=%0d sys_rst=%0d ready=%0d", tag, state_o, sys_rst, ready);
  endtask

  // One-cycle lock dropout in RUN sampled at edge 0: FAULT after edge 2 for
  // 4 cycles, WAIT_LOCK after edge 6, STABILIZE after 7, RUN after 15.
  task automatic loss_event(input string tag, input int cnt_before, input int cnt_after,
                            input bit clr_at_u2);
    int st;
    for (int j = 0; j <= 15; j++) begin
      locked      = (j != 0);
      clear_count = clr_at_u2 && (j == 2);
      tick();
      st = (j < 2) ? 2 : (j < 6) ? 3 : (j == 6) ? 0 : (j < 15) ? 1 : 2;
      check_outs($sformatf("%s.u%0d", tag, j), st, (j < 2) ? cnt_before : cnt_after);
    end
    clear_count = 1'b0;
    $display("loss %s: count=%0d state=%0d", tag, lock_lost_count, state_o);
  endtask

  initial begin
    int st;
    rst         = 1'b1;
    locked      = 1'b0;
    clear_count = 1'b0;

    // Reset held 3 cycles with no lock.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("rst%0d", i), 0, 0);
    end
    rst = 1'b0;
    $display("reset: state=%0d sys_rst=%0d", state_o, sys_rst);

    // No lock: remains in WAIT_LOCK.
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("wait%0d.state", i), state_o, 0);
    end
    check("wait.sys_rst", sys_rst, 1);
    $display("wait: state=%0d after 20 edges", state_o);

    // Glitch during STABILIZE: locked low at edges 6..8 (FSM sees it with
    // cnt=5 at edge 8), high again from edge 9 which restarts the lock.
    for (int i = 0; i <= 19; i++) begin
      locked = !(i >= 6 && i <= 8);
      tick();
      st = (i < 2) ? 0 : (i < 8) ? 1 : (i < 11) ? 0 : (i < 19) ? 1 : 2;
      check_outs($sformatf("glitch.e%0d", i), st, 0);
    end
    $display("glitch: state=%0d count=%0d", state_o, lock_lost_count);

    // Lock losses in RUN: count 1,2,3 then saturated at 3.
    loss_event("loss1", 0, 1, 1'b0);
    loss_event("loss2", 1, 2, 1'b0);
    loss_event("loss3", 2, 3, 1'b0);
    loss_event("loss4", 3, 3, 1'b0);
    // Clear on the same edge as a fifth RUN->FAULT transition gives 1.
    loss_event("loss5clr", 3, 1, 1'b1);

    // Clear alone.
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    check_outs("clear", 2, 0);
    $display("clear: count=%0d", lock_lost_count);

    // Give the counter something to clear, then reset in RUN.
    loss_event("loss6", 0, 1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outs("rst_run", 0, 0);
    $display("rst in run: state=%0d sys_rst=%0d ready=%0d", state_o, sys_rst, ready);

    // Synchroniser was cleared, so re-lock takes the full 10 edges.
    clean_lock("relock", 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
